// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared register-table widths, requester indices and arbiter FSM encoding
//
// Purpose : common definitions for the register-table access arbiter.
// Ports   : none (package).
package reg_pkg;

    localparam int REG_AW = 7;
    localparam int REG_DW = 16;

    // Requester slots on the shared table port.
    localparam int REQ_SPI = 0;
    localparam int REQ_TTE = 1;
    localparam int REQ_P0  = 2;
    localparam int REQ_P1  = 3;
    localparam int REQ_P2  = 4;
    localparam int REQ_P3  = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } arb_state_e;

endpackage

// File: rtl/reg_rr_arb_if.sv
// rtl/reg_rr_arb_if.sv - requester bus and register-table port bundle for reg_rr_arb
//
// Purpose : groups the requester handshake and the table access port.
// Signals : req/we/addr/wdata (requesters -> arbiter), ack/rdata/busy (arbiter -> requesters),
//           tbl_wr/tbl_rd/tbl_addr/tbl_din (arbiter -> table), tbl_dout (table -> arbiter).
// Modports: slave = arbiter side, master = requester/table side.
interface reg_rr_arb_if
    import reg_pkg::*;
#(
    parameter int NREQ = 6,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic               busy;
    logic               tbl_wr;
    logic               tbl_rd;
    logic [AW-1:0]      tbl_addr;
    logic [DW-1:0]      tbl_din;
    logic [DW-1:0]      tbl_dout;

    modport slave (
        input  req, we, addr, wdata, tbl_dout,
        output ack, rdata, busy, tbl_wr, tbl_rd, tbl_addr, tbl_din
    );

    modport master (
        output req, we, addr, wdata, tbl_dout,
        input  ack, rdata, busy, tbl_wr, tbl_rd, tbl_addr, tbl_din
    );

endinterface

// File: rtl/reg_rr_arb_rr_pick.sv
// rtl/reg_rr_arb_rr_pick.sv - combinational round-robin picker
//
// Purpose : returns the first eligible requester (req_i & ~mask_i) searching upward
//           from ptr_i+1, wrapping modulo NREQ.
// Ports   : req_i, mask_i (NREQ), ptr_i (IW) in; gnt_o (one-hot), gnt_idx_o, valid_o out.
module rr_pick #(
    parameter int NREQ = 6,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] mask_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            valid_o
);

    logic [NREQ-1:0] elig;
    logic [IW-1:0]   idx;

    always_comb begin
        elig      = req_i & ~mask_i;
        idx       = '0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        valid_o   = 1'b0;
        // k = NREQ lands back on ptr_i itself, so the last grantee is considered last.
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(ptr_i) + k) % NREQ);
            if (!valid_o && elig[idx]) begin
                valid_o    = 1'b1;
                gnt_idx_o  = idx;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_rr_arb.sv
// rtl/reg_rr_arb.sv - round-robin read/write arbiter for the shared register-table port
//
// Purpose : serialises requester accesses onto one table port, issues one-cycle
//           write/read strobes and returns read data with a one-hot ack pulse.
// Ports   : clk, rst_n (async active-low); bus = reg_rr_arb_if.slave carrying
//           req/we/addr/wdata in, ack/rdata/busy out, tbl_wr/tbl_rd/tbl_addr/tbl_din out,
//           tbl_dout in. All outputs are registered.
module reg_rr_arb
    import reg_pkg::*;
#(
    parameter int NREQ   = 6,
    parameter int AW     = REG_AW,
    parameter int DW     = REG_DW,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_rr_arb_if.slave  bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            we_q, we_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] ack_dly_q;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            busy_q, busy_d;
    logic            tbl_wr_q, tbl_wr_d;
    logic            tbl_rd_q, tbl_rd_d;
    logic [AW-1:0]   tbl_addr_q, tbl_addr_d;
    logic [DW-1:0]   tbl_din_q, tbl_din_d;

    logic [AW-1:0]   addr_a  [NREQ];
    logic [DW-1:0]   wdata_a [NREQ];
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i]  = bus.addr[i*AW +: AW];
        assign wdata_a[i] = bus.wdata[i*DW +: DW];
    end

    // ack_dly_q hides a requester that is still lowering req right after its ack.
    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i     (bus.req),
        .mask_i    (ack_dly_q),
        .ptr_i     (ptr_q),
        .gnt_o     (pick_gnt),
        .gnt_idx_o (pick_idx),
        .valid_o   (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        rdata_d    = rdata_q;
        tbl_wr_d   = 1'b0;
        tbl_rd_d   = 1'b0;
        tbl_addr_d = tbl_addr_q;
        tbl_din_d  = tbl_din_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_d      = pick_gnt;
                    ptr_d      = pick_idx;
                    we_d       = bus.we[pick_idx];
                    tbl_addr_d = addr_a[pick_idx];
                    tbl_din_d  = wdata_a[pick_idx];
                    tbl_wr_d   = bus.we[pick_idx];
                    tbl_rd_d   = ~bus.we[pick_idx];
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (we_q || RD_LAT == 0) begin
                    ack_d   = gnt_q;
                    state_d = ST_ACK;
                    if (!we_q) begin
                        rdata_d = bus.tbl_dout;
                    end
                end else begin
                    cnt_d   = 2'(RD_LAT - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    ack_d   = gnt_q;
                    rdata_d = bus.tbl_dout;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= IW'(NREQ - 1);
            gnt_q      <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            ack_q      <= '0;
            ack_dly_q  <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            tbl_wr_q   <= 1'b0;
            tbl_rd_q   <= 1'b0;
            tbl_addr_q <= '0;
            tbl_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            ack_dly_q  <= ack_q;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            tbl_wr_q   <= tbl_wr_d;
            tbl_rd_q   <= tbl_rd_d;
            tbl_addr_q <= tbl_addr_d;
            tbl_din_q  <= tbl_din_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = busy_q;
    assign bus.tbl_wr   = tbl_wr_q;
    assign bus.tbl_rd   = tbl_rd_q;
    assign bus.tbl_addr = tbl_addr_q;
    assign bus.tbl_din  = tbl_din_q;

endmodule

// File: tb/tb_reg_rr_arb.sv
// tb/tb_reg_rr_arb.sv - directed self-checking bench for reg_rr_arb (RD_LAT 1 and 3)
module tb_reg_rr_arb;

    logic clk;
    logic rst1_n;
    logic rst3_n;
    int   vectors;
    int   errs;

    reg_rr_arb_if #(.NREQ(6), .AW(7), .DW(16)) if1 ();
    reg_rr_arb_if #(.NREQ(6), .AW(7), .DW(16)) if3 ();

    reg_rr_arb #(.NREQ(6), .AW(7), .DW(16), .RD_LAT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .bus   (if1)
    );

    reg_rr_arb #(.NREQ(6), .AW(7), .DW(16), .RD_LAT(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst3_n),
        .bus   (if3)
    );

    // Table content: 0x10 holds 0x1234, every other address reads addr ^ 0xBEEF.
    assign if1.tbl_dout = (if1.tbl_addr == 7'h10) ? 16'h1234 : (16'(if1.tbl_addr) ^ 16'hBEEF);
    assign if3.tbl_dout = (if3.tbl_addr == 7'h10) ? 16'h1234 : (16'(if3.tbl_addr) ^ 16'hBEEF);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int nack;
        int last;
        int both;
        int quiet;

        vectors = 0;
        errs    = 0;
        rst1_n  = 1'b0;
        rst3_n  = 1'b0;
        if1.req = '0; if1.we = '0; if1.addr = '0; if1.wdata = '0;
        if3.req = '0; if3.we = '0; if3.addr = '0; if3.wdata = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_outs_lat1", {if1.ack, if1.busy, if1.tbl_wr, if1.tbl_rd, if1.tbl_addr, if1.tbl_din, if1.rdata}, 64'h0);
        chk("rst_outs_lat3", {if3.ack, if3.busy, if3.tbl_wr, if3.tbl_rd, if3.tbl_addr, if3.tbl_din, if3.rdata}, 64'h0);
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", if1.busy, 1'b0);

        // All six requesters writing continuously: order 0..5,0,1, acks 3 cycles apart
        for (int i = 0; i < 6; i++) begin
            if1.addr[i*7 +: 7]    = 7'(8'h20 + i);
            if1.wdata[i*16 +: 16] = 16'(16'h0100 + i);
        end
        if1.we  = 6'b111111;
        if1.req = 6'b111111;
        nack = 0; last = 0; both = 0;
        for (int c = 1; c <= 40 && nack < 8; c++) begin
            @(negedge clk);
            if (if1.tbl_wr && if1.tbl_rd) both++;
            if (if1.ack != 6'b0) begin
                chk("all_req_ack_order", 64'(if1.ack), 64'(1) << (nack % 6));
                chk("all_req_ack_gap", 64'(c - last), (nack == 0) ? 64'd2 : 64'd3);
                last = c;
                nack++;
                if (nack == 8) if1.req = '0;
            end
        end
        chk("all_req_ack_count", 64'(nack), 64'd8);
        chk("all_req_dual_strobe", 64'(both), 64'd0);
        if1.req = '0;
        repeat (2) @(negedge clk);

        // Single continuous requester 5: acks 4 cycles apart
        if1.we                = 6'b100000;
        if1.addr[5*7 +: 7]    = 7'h35;
        if1.wdata[5*16 +: 16] = 16'h5555;
        if1.req               = 6'b100000;
        nack = 0; last = 0; both = 0;
        for (int c = 1; c <= 40 && nack < 4; c++) begin
            @(negedge clk);
            if (if1.tbl_wr && if1.tbl_rd) both++;
            if (if1.ack != 6'b0) begin
                chk("single_req_ack", 64'(if1.ack), 64'h20);
                chk("single_req_gap", 64'(c - last), (nack == 0) ? 64'd2 : 64'd4);
                last = c;
                nack++;
                if (nack == 4) if1.req = '0;
            end
        end
        chk("single_req_count", 64'(nack), 64'd4);
        chk("single_req_dual_strobe", 64'(both), 64'd0);
        if1.req = '0;
        repeat (2) @(negedge clk);

        // Single write from requester 2
        if1.we                = 6'b000100;
        if1.addr[2*7 +: 7]    = 7'h02;
        if1.wdata[2*16 +: 16] = 16'h00A5;
        if1.req               = 6'b000100;
        @(negedge clk);
        chk("wr_c1_strobes", {if1.tbl_wr, if1.tbl_rd, if1.busy}, 3'b101);
        chk("wr_c1_addr", if1.tbl_addr, 7'h02);
        chk("wr_c1_din", if1.tbl_din, 16'h00A5);
        chk("wr_c1_noack", if1.ack, 6'b0);
        @(negedge clk);
        chk("wr_c2_ack", if1.ack, 6'b000100);
        if1.req = '0;
        @(negedge clk);
        chk("wr_c3_idle", {if1.busy, if1.ack}, 7'b0);

        // Read from requester 0, RD_LAT = 1
        if1.we             = 6'b000000;
        if1.addr[0 +: 7]   = 7'h10;
        if1.req            = 6'b000001;
        @(negedge clk);
        chk("rd1_c1_strobes", {if1.tbl_rd, if1.tbl_wr}, 2'b10);
        chk("rd1_c1_addr", if1.tbl_addr, 7'h10);
        @(negedge clk);
        chk("rd1_c2_wait", {if1.ack, if1.tbl_rd, if1.busy}, 8'b00000001);
        @(negedge clk);
        chk("rd1_c3_ack", if1.ack, 6'b000001);
        chk("rd1_c3_rdata", if1.rdata, 16'h1234);
        if1.req = '0;
        @(negedge clk);

        // Requester 3 served; 1 and 4 arrive in its ack cycle -> grant 4 then 1
        if1.we             = 6'b011010;
        if1.addr[3*7 +: 7] = 7'h43;
        if1.addr[4*7 +: 7] = 7'h44;
        if1.addr[1*7 +: 7] = 7'h41;
        if1.req            = 6'b001000;
        @(negedge clk);
        chk("rr_c1_addr3", if1.tbl_addr, 7'h43);
        @(negedge clk);
        chk("rr_c2_ack3", if1.ack, 6'b001000);
        if1.req = 6'b010010;
        @(negedge clk);
        chk("rr_c3_idle", if1.busy, 1'b0);
        @(negedge clk);
        chk("rr_c4_addr4", {if1.tbl_wr, if1.tbl_addr}, {1'b1, 7'h44});
        @(negedge clk);
        chk("rr_c5_ack4", if1.ack, 6'b010000);
        if1.req = 6'b000010;
        @(negedge clk);
        @(negedge clk);
        chk("rr_c7_addr1", {if1.tbl_wr, if1.tbl_addr}, {1'b1, 7'h41});
        @(negedge clk);
        chk("rr_c8_ack1", if1.ack, 6'b000010);
        if1.req = '0;
        @(negedge clk);

        // RD_LAT = 3 read from requester 2: ack and rdata in cycle 5
        if3.we             = 6'b000000;
        if3.addr[2*7 +: 7] = 7'h22;
        if3.req            = 6'b000100;
        @(negedge clk);
        chk("rd3_c1", {if3.tbl_rd, if3.tbl_addr}, {1'b1, 7'h22});
        repeat (3) @(negedge clk);
        chk("rd3_c4_noack", {if3.ack, if3.busy}, 7'b0000001);
        @(negedge clk);
        chk("rd3_c5_ack", if3.ack, 6'b000100);
        chk("rd3_c5_rdata", if3.rdata, 16'hBECD);
        if3.req = '0;
        @(negedge clk);

        // Reset while a read from requester 0 sits in WAIT
        if3.addr[0 +: 7] = 7'h30;
        if3.req          = 6'b000001;
        @(negedge clk);
        chk("rst_wait_c1", {if3.tbl_rd, if3.tbl_addr}, {1'b1, 7'h30});
        @(negedge clk);
        chk("rst_wait_c2", {if3.tbl_rd, if3.ack, if3.busy, if3.tbl_addr}, {1'b0, 6'b0, 1'b1, 7'h30});
        #2;
        rst3_n  = 1'b0;
        if3.req = '0;
        #1;
        chk("rst_async_clear", {if3.ack, if3.busy, if3.tbl_wr, if3.tbl_rd, if3.tbl_addr, if3.tbl_din, if3.rdata}, 64'h0);
        @(negedge clk);
        chk("rst_held_clear", {if3.ack, if3.busy, if3.tbl_wr, if3.tbl_rd, if3.tbl_addr}, 64'h0);
        rst3_n = 1'b1;
        quiet = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (if3.ack != 6'b0 || if3.busy || if3.tbl_wr || if3.tbl_rd) quiet++;
        end
        chk("rst_no_late_ack", 64'(quiet), 64'd0);
        if3.addr[1*7 +: 7] = 7'h31;
        if3.req            = 6'b000011;
        @(negedge clk);
        chk("rst_regrant_idx0", {if3.tbl_rd, if3.tbl_addr}, {1'b1, 7'h30});
        repeat (4) @(negedge clk);
        chk("rst_regrant_ack", if3.ack, 6'b000001);
        chk("rst_regrant_rdata", if3.rdata, 16'hBEDF);
        if3.req = '0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
